// File: rtl/crop_packer.sv
// -----------------------------------------------------------------------------
// crop_packer
//
// Packs the 8-bit crop-pixel stream from the crop inference stage into
// 256-bit words for the output DMA path. Crops are packed one at a time.
// Pixel k of a word is placed in bits [8k+7:8k]. The last word of each crop
// is zero-padded. The first word of the frame is flagged on tuser, and the
// last word of the frame is flagged on tlast.
//
// Optional feature (macro CROP_HEADER_EN):
//   When defined, a header word is emitted before each crop's data:
//   [7:0]=8'hA5, [15:8]=crop counter, [31:16]=CROP_PIX, rest zero.
//   When undefined, only data words are emitted.
//
// Ports:
//   clk            sole clock
//   reset          asynchronous, active-high reset
//   s_axis_tvalid  pixel valid
//   s_axis_tready  pixel accept
//   s_axis_tdata   Mono8 pixel
//   s_crop_idx     crop index of the current pixel; checked at each crop's
//                  first pixel
//   m_axis_tvalid  packed word valid
//   m_axis_tready  downstream accept
//   m_axis_tdata   packed 256-bit word
//   m_axis_tuser   first word of frame
//   m_axis_tlast   last word of frame
//   frame_done     one-cycle pulse while the tlast word handshakes
//   err_crop_seq   sticky crop-order error; only reset clears it
// -----------------------------------------------------------------------------
module crop_packer #(
  parameter  int OUT_ROWS  = 20,
  parameter  int OUT_COLS  = 20,
  parameter  int NUM_CROPS = 3,
  localparam int IDX_W     = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [7:0]       s_axis_tdata,
  input  logic [IDX_W-1:0] s_crop_idx,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [255:0]     m_axis_tdata,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             frame_done,
  output logic             err_crop_seq
);

  localparam int CROP_PIX = OUT_ROWS * OUT_COLS;
  localparam int PIX_W    = (CROP_PIX > 1) ? $clog2(CROP_PIX) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(CROP_PIX - 1);
  localparam logic [PIX_W-1:0] PIX_ZERO  = {PIX_W{1'b0}};
  localparam logic [IDX_W-1:0] CROP_LAST = IDX_W'(NUM_CROPS - 1);
  localparam logic [IDX_W-1:0] CROP_ZERO = {IDX_W{1'b0}};

`ifdef CROP_HEADER_EN
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_HDR   = 2'd1,
    S_DATA  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_DATA  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [4:0]       byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] crop_cnt_q, crop_cnt_d;
  logic [255:0]     acc_q, acc_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [255:0]     out_data_q, out_data_d;
  logic             out_user_q, out_user_d;
  logic             out_last_q, out_last_d;

  logic             free_s;
  logic             crop_end_s;
  logic             word_end_s;
  logic [255:0]     word_s;
  logic             load_s;
  logic [255:0]     load_word_s;
  logic             load_user_s;
  logic             load_crop_end_s;
  logic             s_tready_s;

  // Next-state, counter, accumulator and output-register logic
  always_comb begin
    state_d         = state_q;
    pix_cnt_d       = pix_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    crop_cnt_d      = crop_cnt_q;
    acc_d           = acc_q;
    first_d         = first_q;
    err_d           = err_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_user_d      = out_user_q;
    out_last_d      = out_last_q;
    s_tready_s      = 1'b0;
    load_s          = 1'b0;
    load_word_s     = 256'd0;
    load_user_s     = 1'b0;
    load_crop_end_s = 1'b0;

    free_s     = !out_valid_q || m_axis_tready;
    crop_end_s = (pix_cnt_q == PIX_LAST);
    word_end_s = (byte_cnt_q == 5'd31) || crop_end_s;
    // The accumulator is cleared after every load, so unused bytes stay zero.
    word_s     = acc_q | ({248'd0, s_axis_tdata} << {byte_cnt_q, 3'b000});

    // A drained word frees the register; a load below overrides this.
    if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      S_START: begin
`ifdef CROP_HEADER_EN
        state_d = S_HDR;
`else
        state_d = S_DATA;
        first_d = 1'b1;
`endif
      end
`ifdef CROP_HEADER_EN
      S_HDR: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_word_s = {224'd0, 16'(CROP_PIX), 8'(crop_cnt_q), 8'hA5};
          load_user_s = (crop_cnt_q == CROP_ZERO);
          state_d     = S_DATA;
        end else begin
          state_d     = S_HDR;
        end
      end
`endif
      S_DATA: begin
        s_tready_s = 1'b1;
        if (s_axis_tvalid) begin
          pix_cnt_d  = crop_end_s ? PIX_ZERO : pix_cnt_q + 1'b1;
          byte_cnt_d = word_end_s ? 5'd0 : byte_cnt_q + 5'd1;
          if ((pix_cnt_q == PIX_ZERO) && (s_crop_idx != crop_cnt_q)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (word_end_s && free_s) begin
            load_s          = 1'b1;
            load_word_s     = word_s;
            load_user_s     = first_q && (crop_cnt_q == CROP_ZERO);
            load_crop_end_s = crop_end_s;
            acc_d           = 256'd0;
          end else if (word_end_s) begin
            acc_d   = word_s;
            state_d = S_HOLD;
          end else begin
            acc_d   = word_s;
          end
        end else begin
          acc_d = acc_q;
        end
      end
      S_HOLD: begin
        if (free_s) begin
          load_s          = 1'b1;
          load_word_s     = acc_q;
          load_user_s     = first_q && (crop_cnt_q == CROP_ZERO);
          // The pixel counter already wrapped if the held word ends the crop.
          load_crop_end_s = (pix_cnt_q == PIX_ZERO);
          acc_d           = 256'd0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_START;
      end
    endcase

    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = load_word_s;
      out_user_d  = load_user_s;
      out_last_d  = load_crop_end_s && (crop_cnt_q == CROP_LAST);
      first_d     = 1'b0;
    end else begin
      out_data_d  = out_data_q;
    end

    // Data-word loads pick the next state. A header load has already
    // selected S_DATA above.
    if (load_s && (state_q != S_START) && (state_q == S_DATA || state_q == S_HOLD)) begin
      if (load_crop_end_s) begin
        state_d    = S_START;
        crop_cnt_d = (crop_cnt_q == CROP_LAST) ? CROP_ZERO : crop_cnt_q + 1'b1;
      end else begin
        state_d    = S_DATA;
      end
    end else begin
      crop_cnt_d = crop_cnt_q;
    end
  end

  // State, counters, accumulator and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_START;
      pix_cnt_q   <= PIX_ZERO;
      byte_cnt_q  <= 5'd0;
      crop_cnt_q  <= CROP_ZERO;
      acc_q       <= 256'd0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 256'd0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crop_cnt_q  <= crop_cnt_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
    end
  end

  assign s_axis_tready = s_tready_s;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tlast  = out_last_q;
  assign frame_done    = out_valid_q && m_axis_tready && out_last_q;
  assign err_crop_seq  = err_q;

endmodule

// File: tb/tb_crop_packer.sv
`timescale 1ns/1ps
module tb_crop_packer;

  localparam int NUM_CROPS = 3;
  localparam int CROP_PIX  = 400;
  localparam int WPC       = (CROP_PIX + 31) / 32;
`ifdef CROP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int WPF = NUM_CROPS * (WPC + HDR);

  typedef struct packed {
    logic [255:0] d;
    logic         u;
    logic         l;
  } word_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [7:0]   s_tdata = 8'd0;
  logic [1:0]   s_idx = 2'd0;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [255:0] m_tdata;
  logic         m_tuser;
  logic         m_tlast;
  logic         frame_done;
  logic         err_crop_seq;

  word_t        exp_q[$];
  logic [7:0]   pix_mem [NUM_CROPS][CROP_PIX];
  logic [255:0] cap [64];
  int           errors = 0;
  int           checks = 0;
  int           rdy_mode = 0;
  int           accepted = 0;
  int           last_frame_words = 0;
  int           done_cnt = 0;
  int           exp_done = 0;
  bit           chk_seq_err = 1'b0;

  crop_packer dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_crop_idx    (s_idx),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .frame_done    (frame_done),
    .err_crop_seq  (err_crop_seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference model: the frame is sliced into 32-byte words straight from the pixel array.
  task automatic push_frame();
    word_t w;
    int    k;
    for (int c = 0; c < NUM_CROPS; c++) begin
      if (HDR == 1) begin
        w.d = 256'd0;
        w.d[7:0]   = 8'hA5;
        w.d[15:8]  = 8'(c);
        w.d[31:16] = 16'(CROP_PIX);
        w.u = (c == 0);
        w.l = 1'b0;
        exp_q.push_back(w);
      end
      for (int wi = 0; wi < WPC; wi++) begin
        w.d = 256'd0;
        for (int b = 0; b < 32; b++) begin
          k = wi * 32 + b;
          if (k < CROP_PIX) w.d[8*b +: 8] = pix_mem[c][k];
        end
        w.u = (c == 0) && (wi == 0) && (HDR == 0);
        w.l = (c == NUM_CROPS - 1) && (wi == WPC - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic fill(input bit rnd);
    for (int c = 0; c < NUM_CROPS; c++)
      for (int p = 0; p < CROP_PIX; p++)
        pix_mem[c][p] = rnd ? 8'($urandom_range(0, 255)) : 8'(p % 256);
  endtask

  // Entered and left at posedge+1.
  task automatic send_pixel(input logic [7:0] d, input logic [1:0] idx, input int gap);
    bit acc;
    int n;
    while ($urandom_range(0, 99) < gap) begin
      @(posedge clk); #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_idx    = idx;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL pixel_accept_timeout: got no tready required tready within 2000 cycles");
    end else begin
      accepted++;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int s0, input int s1, input int s2, input int gap,
                            input int ab_c, input int ab_p);
    int seq [3];
    seq = '{s0, s1, s2};
    for (int c = 0; c < NUM_CROPS; c++) begin
      for (int p = 0; p < CROP_PIX; p++) begin
        send_pixel(pix_mem[c][p], 2'(seq[c]), gap);
        if (chk_seq_err && c == 0 && p == CROP_PIX - 1) check("err_before_bad_crop", 256'(err_crop_seq), 256'd0);
        if (chk_seq_err && c == 1 && p == 0) check("err_at_bad_crop", 256'(err_crop_seq), 256'd1);
        if (c == ab_c && p == ab_p) return;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 256'(exp_q.size()), 256'd0);
  endtask

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        2: m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake
  initial begin
    word_t        e;
    bit           hold_v;
    logic [257:0] hold_w;
    int           fw;
    hold_v = 1'b0;
    hold_w = 258'd0;
    fw = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
        fw = 0;
      end else begin
        if (hold_v && m_tvalid) check("stall_stable", 256'({m_tdata, m_tuser, m_tlast} == hold_w), 256'd1);
        hold_v = m_tvalid && !m_tready;
        hold_w = {m_tdata, m_tuser, m_tlast};
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_word: got %h required no word", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("tdata", m_tdata, e.d);
            check("tuser", 256'(m_tuser), 256'(e.u));
            check("tlast", 256'(m_tlast), 256'(e.l));
            check("frame_done", 256'(frame_done), 256'(e.l));
          end
          if (fw < 64) cap[fw] = m_tdata;
          fw++;
          if (m_tlast) begin
            last_frame_words = fw;
            fw = 0;
          end
        end else begin
          check("frame_done_idle", 256'(frame_done), 256'd0);
        end
        if (frame_done) done_cnt++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 256'(m_tvalid), 256'd0);
    check({tag, "_tdata"}, m_tdata, 256'd0);
    check({tag, "_tuser"}, 256'(m_tuser), 256'd0);
    check({tag, "_tlast"}, 256'(m_tlast), 256'd0);
    check({tag, "_frame_done"}, 256'(frame_done), 256'd0);
    check({tag, "_err"}, 256'(err_crop_seq), 256'd0);
    check({tag, "_s_tready"}, 256'(s_tready), 256'd0);
  endtask

  initial begin
    logic [255:0] w12;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: index pattern, ready held high
    fill(1'b0);
    last_frame_words = 0;
    push_frame();
    send_frame(0, 1, 2, 0, -1, -1);
    wait_drain();
    exp_done++;
    check("s1_words", 256'(last_frame_words), 256'(WPF));
`ifdef CROP_HEADER_EN
    check("s1_hdr_word0", cap[0], 256'h0190_00A5);
    check("s1_hdr_crop1", 256'(cap[14][15:8]), 256'd1);
`else
    w12 = 256'd0;
    for (int b = 0; b < 16; b++) w12[8*b +: 8] = 8'(128 + b);
    check("s1_word12", cap[12], w12);
`endif
    check("s1_err", 256'(err_crop_seq), 256'd0);

    // 2: toggling ready, random source gaps, same pixels
    rdy_mode = 1;
    last_frame_words = 0;
    push_frame();
    send_frame(0, 1, 2, 50, -1, -1);
    wait_drain();
    exp_done++;
    rdy_mode = 0;
    check("s2_words", 256'(last_frame_words), 256'(WPF));

    // 3: downstream stalled at frame start, long enough for two words to fill
    repeat (4) @(posedge clk); #1;
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    fill(1'b1);
    last_frame_words = 0;
    accepted = 0;
    push_frame();
    fork
      send_frame(0, 1, 2, 0, -1, -1);
      begin
        repeat (80 + HDR) @(posedge clk);
        @(negedge clk);
        check("s3_accepted", 256'(accepted), 256'd64);
        check("s3_s_tready", 256'(s_tready), 256'd0);
        check("s3_m_tvalid", 256'(m_tvalid), 256'd1);
        rdy_mode = 0;
      end
    join
    wait_drain();
    exp_done++;
    check("s3_words", 256'(last_frame_words), 256'(WPF));

    // 4: reset at pixel 200 of crop 1, then a clean frame
    fill(1'b0);
    push_frame();
    send_frame(0, 1, 2, 0, 1, 200);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    last_frame_words = 0;
    push_frame();
    send_frame(0, 1, 2, 0, -1, -1);
    wait_drain();
    exp_done++;
    check("s4_words", 256'(last_frame_words), 256'(WPF));
    check("s4_err", 256'(err_crop_seq), 256'd0);

    // 5: out-of-order crop indices, random pixels
    fill(1'b1);
    last_frame_words = 0;
    chk_seq_err = 1'b1;
    push_frame();
    send_frame(0, 2, 1, 20, -1, -1);
    chk_seq_err = 1'b0;
    wait_drain();
    exp_done++;
    check("s5_words", 256'(last_frame_words), 256'(WPF));
    check("s5_err", 256'(err_crop_seq), 256'd1);

    repeat (3) @(posedge clk);
    check("frame_done_count", 256'(done_cnt), 256'(exp_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
